// File: rtl/rf_wb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
// Optional feature macro used by the top: WB_LSU_BYPASS_EN.
package rf_wb_pkg;

   localparam int unsigned WB_DEPTH  = 4;
   localparam int unsigned WB_ADDR_W = 5;
   localparam int unsigned WB_DATA_W = 32;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   // Occupancy counters need one extra bit so that "full" (== depth) is representable.
   function automatic int unsigned wb_cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// LSU result buffer: power-of-two circular FIFO with an occupancy counter and a
// per-entry address/valid tap used for the decode-stage hazard query.
module wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int unsigned DEPTH      = WB_DEPTH,
   parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
   parameter int unsigned DATA_WIDTH = WB_DATA_W,
   localparam int unsigned CW        = wb_cnt_w(DEPTH),
   localparam int unsigned PW        = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic [ADDR_WIDTH-1:0]            push_addr,
   input  logic [DATA_WIDTH-1:0]            push_data,
   input  logic                             pop,
   output logic [ADDR_WIDTH-1:0]            head_addr,
   output logic [DATA_WIDTH-1:0]            head_data,
   output logic                             full,
   output logic                             empty,
   output logic [CW-1:0]                    count,
   output logic [DEPTH-1:0]                 entry_valid,
   output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr
);

   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;

   logic w_push_ok;
   logic w_pop_ok;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign w_push_ok = push & ~full;
   assign w_pop_ok  = pop & ~empty;
   assign head_addr = r_addr[r_rd_ptr];
   assign head_data = r_data[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_addr[r_wr_ptr] <= push_addr;
         r_data[r_wr_ptr] <= push_data;
      end
   end

   // An entry is live when its distance from the read pointer is below the count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_tap
      logic [PW-1:0] w_off;
      assign w_off          = PW'(g) - r_rd_ptr;
      assign entry_valid[g] = ({1'b0, w_off} < r_count);
      assign entry_addr[g]  = r_addr[g];
   end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file write-port arbiter: ALU has absolute priority, LSU results are
// buffered in order. Define WB_LSU_BYPASS_EN to let an LSU result skip an empty buffer.
module rf_wb_arb
   import rf_wb_pkg::*;
#(
   parameter int unsigned DEPTH      = WB_DEPTH,
   parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
   parameter int unsigned DATA_WIDTH = WB_DATA_W,
   localparam int unsigned CW        = wb_cnt_w(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  wr_enable1,
   output logic [ADDR_WIDTH-1:0] wr_addr1,
   output logic [DATA_WIDTH-1:0] wr_data1,
   input  logic [ADDR_WIDTH-1:0] query_addr,
   output logic                  query_pending,
   output logic [CW-1:0]         lsu_count
);

   logic                             w_full;
   logic                             w_empty;
   logic [ADDR_WIDTH-1:0]            w_head_addr;
   logic [DATA_WIDTH-1:0]            w_head_data;
   logic [DEPTH-1:0]                 w_entry_valid;
   logic [DEPTH-1:0][ADDR_WIDTH-1:0] w_entry_addr;
   logic                             w_accept;
   logic                             w_bypass;
   logic                             w_push;
   logic                             w_pop;
   logic                             w_fifo_hit;

   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;

   // LSU handshake: a result transfers on any cycle where lsu_valid && lsu_ready.
   // lsu_ready depends only on occupancy, never on a same-cycle pop.
   assign lsu_ready = ~w_full;
   assign w_accept  = lsu_valid & lsu_ready;

`ifdef WB_LSU_BYPASS_EN
   assign w_bypass = w_accept & ~alu_valid & w_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = w_accept & ~w_bypass;
   assign w_pop  = ~alu_valid & ~w_empty;

   wb_fifo #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk         (clock),
      .rst         (reset),
      .push        (w_push),
      .push_addr   (lsu_addr),
      .push_data   (lsu_data),
      .pop         (w_pop),
      .head_addr   (w_head_addr),
      .head_data   (w_head_data),
      .full        (w_full),
      .empty       (w_empty),
      .count       (lsu_count),
      .entry_valid (w_entry_valid),
      .entry_addr  (w_entry_addr)
   );

   // Writes to x0 are consumed like any other request but never enabled.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (alu_valid) begin
         r_wr_en   <= (alu_addr != '0);
         r_wr_addr <= alu_addr;
         r_wr_data <= alu_data;
      end else if (w_pop) begin
         r_wr_en   <= (w_head_addr != '0);
         r_wr_addr <= w_head_addr;
         r_wr_data <= w_head_data;
      end else if (w_bypass) begin
         r_wr_en   <= (lsu_addr != '0);
         r_wr_addr <= lsu_addr;
         r_wr_data <= lsu_data;
      end else begin
         r_wr_en   <= 1'b0;
      end
   end

   assign wr_enable1 = r_wr_en;
   assign wr_addr1   = r_wr_addr;
   assign wr_data1   = r_wr_data;

   always_comb begin
      w_fifo_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_entry_valid[i] && (w_entry_addr[i] == query_addr)) w_fifo_hit = 1'b1;
      end
   end

   assign query_pending = (query_addr != '0) &
                          (w_fifo_hit | (r_wr_en & (r_wr_addr == query_addr)));

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed-then-random bench for rf_wb_arb against a queue-based reference model.
// Honours WB_LSU_BYPASS_EN the same way the design does.
module tb_rf_wb_arb;
   import rf_wb_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned W     = $bits(wb_req_t);

   logic          clock;
   logic          reset;
   logic          alu_valid;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          lsu_valid;
   logic          lsu_ready;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_data;
   logic          wr_enable1;
   logic [AW-1:0] wr_addr1;
   logic [DW-1:0] wr_data1;
   logic [AW-1:0] query_addr;
   logic          query_pending;
   logic [2:0]    lsu_count;

   rf_wb_arb #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock         (clock),
      .reset         (reset),
      .alu_valid     (alu_valid),
      .alu_addr      (alu_addr),
      .alu_data      (alu_data),
      .lsu_valid     (lsu_valid),
      .lsu_ready     (lsu_ready),
      .lsu_addr      (lsu_addr),
      .lsu_data      (lsu_data),
      .wr_enable1    (wr_enable1),
      .wr_addr1      (wr_addr1),
      .wr_data1      (wr_data1),
      .query_addr    (query_addr),
      .query_pending (query_pending),
      .lsu_count     (lsu_count)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // stimulus state: per-cycle ALU request, held LSU offer, query address
   bit          g_rst;
   bit          g_alu_v;
   logic [AW-1:0] g_alu_a;
   logic [DW-1:0] g_alu_d;
   logic [AW-1:0] g_q;
   bit          offer_v;
   logic [AW-1:0] offer_a;
   logic [DW-1:0] offer_d;

   // reference model: buffered LSU results in order plus the expected write port
   logic [W-1:0]  exp_q[$];
   bit            e_en;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;
   bit            known;

   int n_pass;
   int n_total;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endtask

   task automatic make_offer(input logic [AW-1:0] a);
      offer_v = 1'b1;
      offer_a = a;
      offer_d = $urandom;
   endtask

   // one clock: drive, check outputs, advance the model across the rising edge
   task automatic tick();
      bit      pend;
      bit      acc;
      wb_req_t h;
      @(negedge clock);
      reset      = g_rst;
      alu_valid  = g_alu_v;
      alu_addr   = g_alu_a;
      alu_data   = g_alu_d;
      lsu_valid  = offer_v & ~g_rst;
      lsu_addr   = offer_a;
      lsu_data   = offer_d;
      query_addr = g_q;
      #1;
      if (known) begin
         chk("wr_enable1", 64'(wr_enable1), 64'(e_en));
         chk("wr_addr1", 64'(wr_addr1), 64'(e_addr));
         chk("wr_data1", 64'(wr_data1), 64'(e_data));
         chk("lsu_count", 64'(lsu_count), 64'(exp_q.size()));
         chk("lsu_ready", 64'(lsu_ready), 64'(exp_q.size() != DEPTH));
         pend = 1'b0;
         if (g_q != '0) begin
            foreach (exp_q[i]) begin
               h = wb_req_t'(exp_q[i]);
               if (h.addr == g_q) pend = 1'b1;
            end
            if (e_en && e_addr == g_q) pend = 1'b1;
         end
         chk("query_pending", 64'(query_pending), 64'(pend));
      end
      if (g_rst) begin
         exp_q.delete();
         e_en    = 1'b0;
         e_addr  = '0;
         e_data  = '0;
         known   = 1'b1;
         offer_v = 1'b0;
      end else begin
         acc = offer_v && (exp_q.size() < DEPTH);
         if (g_alu_v) begin
            e_en = (g_alu_a != '0); e_addr = g_alu_a; e_data = g_alu_d;
         end else if (exp_q.size() > 0) begin
            h = wb_req_t'(exp_q.pop_front());
            e_en = (h.addr != '0); e_addr = h.addr; e_data = h.data;
         end
`ifdef WB_LSU_BYPASS_EN
         else if (acc) begin
            e_en = (offer_a != '0); e_addr = offer_a; e_data = offer_d;
            acc = 1'b0;
            offer_v = 1'b0;
         end
`endif
         else begin
            e_en = 1'b0;
         end
         if (acc) begin
            exp_q.push_back({offer_a, offer_d});
            offer_v = 1'b0;
         end
      end
      @(posedge clock);
   endtask

   initial begin
      int k;
      n_pass  = 0;
      n_total = 0;
      known   = 1'b0;
      offer_v = 1'b0;
      offer_a = '0;
      offer_d = '0;
      g_alu_v = 1'b0;
      g_alu_a = '0;
      g_alu_d = '0;
      g_q     = '0;

      // reset, then ready/idle state on the first free cycle
      g_rst = 1'b1;
      tick();
      tick();
      g_rst = 1'b0;
      tick();

      // ALU write lands one cycle later
      g_alu_v = 1'b1; g_alu_a = 5'd3; g_alu_d = 32'hDEADBEEF;
      tick();
      g_alu_v = 1'b0;
      tick();
      tick();

      // fill the buffer under ALU pressure; fifth offer must be held
      g_alu_v = 1'b1; g_alu_a = 5'd20;
      k = 1;
      repeat (6) begin
         if (!offer_v && k <= 5) begin make_offer(AW'(k)); k++; end
         g_alu_d = $urandom;
         tick();
      end
      // release: drains 1..5 in order on consecutive cycles
      g_alu_v = 1'b0;
      repeat (8) tick();

      // hazard query against a buffered entry, then after its write
      g_alu_v = 1'b1; g_alu_a = 5'd12; g_q = 5'd7;
      make_offer(5'd7);
      tick();
      tick();
      g_alu_v = 1'b0;
      repeat (3) tick();
      g_q = 5'd0;
      make_offer(5'd0);
      tick();
      tick();

      // ALU write to x0 is suppressed
      g_alu_v = 1'b1; g_alu_a = 5'd0; g_alu_d = 32'h1234;
      tick();
      g_alu_v = 1'b0;
      tick();

      // reset with three buffered results discards them
      g_alu_v = 1'b1; g_alu_a = 5'd21;
      k = 1;
      repeat (4) begin
         if (!offer_v && k <= 3) begin make_offer(AW'(k + 8)); k++; end
         g_alu_d = $urandom;
         tick();
      end
      g_alu_v = 1'b0;
      g_rst   = 1'b1;
      tick();
      g_rst   = 1'b0;
      repeat (4) tick();

      // LSU into an empty buffer (latency depends on the bypass build)
      make_offer(5'd9);
      tick();
      repeat (3) tick();

      // randomized traffic with address collisions and rare resets
      repeat (400) begin
         g_rst   = ($urandom_range(0, 99) == 0);
         g_alu_v = ($urandom_range(0, 9) < 4);
         g_alu_a = AW'($urandom_range(0, 7));
         g_alu_d = $urandom;
         g_q     = AW'($urandom_range(0, 7));
         if (!offer_v && $urandom_range(0, 1) == 1) make_offer(AW'($urandom_range(0, 7)));
         tick();
      end
      g_rst = 1'b0; g_alu_v = 1'b0;
      repeat (6) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rf_wb_arb.md
RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning LSU result buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-004 SHALL have port clock  input  1  the only clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port alu_valid  input  1  ALU writeback request, no backpressure.
REQ-007 SHALL have port alu_addr  input  ADDR_WIDTH  ALU destination register.
REQ-008 SHALL have port alu_data  input  DATA_WIDTH  ALU result.
REQ-009 SHALL have port lsu_valid  input  1  load result offered.
REQ-010 SHALL have port lsu_ready  output  1  load result accepted when high with lsu_valid.
REQ-011 SHALL have port lsu_addr  input  ADDR_WIDTH  load destination register.
REQ-012 SHALL have port lsu_data  input  DATA_WIDTH  load data.
REQ-013 SHALL have port wr_enable1  output  1  register file write enable, registered.
REQ-014 SHALL have port wr_addr1  output  ADDR_WIDTH  register file write address, registered.
REQ-015 SHALL have port wr_data1  output  DATA_WIDTH  register file write data, registered.
REQ-016 SHALL have port query_addr  input  ADDR_WIDTH  decode-stage source register to check.
REQ-017 SHALL have port query_pending  output  1  combinational: query_addr has a write not yet committed.
REQ-018 SHALL have port lsu_count  output  $clog2(DEPTH)+1  buffered LSU entries.

Function
REQ-019 SHALL accept an LSU result when lsu_valid && lsu_ready; lsu_ready = (lsu_count != DEPTH), independent of pop in the same cycle.
REQ-020 SHALL give ALU absolute priority: alu_valid cycle loads the output register from ALU inputs; FIFO does not pop.
REQ-021 SHALL pop the FIFO head into the output register in any cycle with alu_valid low and lsu_count > 0.
REQ-022 SHALL drive wr_enable1 low in cycles where nothing is loaded; wr_addr1/wr_data1 hold last values.
REQ-023 SHALL suppress writes to address 0: such requests are consumed (ALU) or accepted and popped (LSU) but produce wr_enable1 = 0.
REQ-024 SHALL keep LSU results in acceptance order; no ordering is enforced between ALU and LSU streams.
REQ-025 SHALL assert query_pending when query_addr != 0 and matches any valid FIFO entry or the output register with wr_enable1 high.
REQ-026 SHALL handle simultaneous push and pop with lsu_count unchanged and wrap read/write pointers modulo DEPTH.
REQ-027 SHALL have ALU latency 1 cycle (request at cycle N, wr_enable1 at N+1).

Reset
REQ-028 SHALL on reset clear FIFO pointers and count, drive wr_enable1 = 0, wr_addr1 = 0, wr_data1 = 0; lsu_ready = 1 the cycle after reset deasserts.
REQ-029 SHALL discard all buffered LSU results on reset asserted mid-operation; no write is issued for them.

Configuration
REQ-030 SHALL, with WB_LSU_BYPASS_EN defined, load an LSU result directly into the output register when FIFO empty and alu_valid low (LSU latency 1, FIFO untouched).
REQ-031 SHALL, without WB_LSU_BYPASS_EN, always route LSU results through the FIFO (minimum LSU latency 2).

Structure
REQ-032 SHALL place wb_req_t (addr, data struct) and default width constants in package rf_wb_pkg.
REQ-033 SHALL implement the LSU buffer as sub-module wb_fifo (push/pop, full/empty, count, per-entry address tap for query).

Verification
REQ-034 SHALL cover: alu_valid=1, addr=3, data=0xDEADBEEF at cycle N -> wr_enable1=1, wr_addr1=3, wr_data1=0xDEADBEEF at N+1.
REQ-035 SHALL cover: 5 back-to-back LSU pushes (addr 1..5) with alu_valid held high, DEPTH=4 -> lsu_ready low after 4th, lsu_count=4, 5th held by producer.
REQ-036 SHALL cover: then alu_valid dropped -> writes to 1,2,3,4,5 in order on consecutive cycles, lsu_count returns to 0.
REQ-037 SHALL cover: LSU addr=7 buffered, query_addr=7 -> query_pending=1; after its write cycle ends -> 0; query_addr=0 -> always 0.
REQ-038 SHALL cover: alu_addr=0, data=0x1234 -> wr_enable1 stays 0.
REQ-039 SHALL cover: reset asserted with lsu_count=3 -> next cycle lsu_count=0, wr_enable1=0, no write for discarded entries; bypass build: empty FIFO, lsu addr=9 -> write at N+1.
